// File: rtl/logic_gate_unit_pkg.sv
// Shared op encodings, BIST state type and sizing constants for the
// logic gate unit.
package logic_gate_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_NAND = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

  localparam int ERR_W   = 16;
  localparam int NUM_OPS = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } bist_state_e;

endpackage

// File: rtl/logic_gate_unit_if.sv
// Input/output handshake bundle of the logic gate unit; master drives
// requests and consumes results, slave is the gate array.
interface logic_gate_unit_if #(
  parameter int N_IN = 2,
  parameter int N_CH = 4
);
  logic [2:0]           op;
  logic                 in_valid;
  logic                 in_ready;
  logic [N_CH*N_IN-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [N_CH-1:0]      out_data;

  modport master (
    output op, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  op, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/logic_gate_unit_gate_channel.sv
// One combinational N_IN-input gate; reserved ops yield 0.
module gate_channel
  import logic_gate_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic [2:0]      op_i,
  input  logic [N_IN-1:0] data_i,
  output logic            y_o
);

  always_comb begin
    y_o = 1'b0;
    case (op_i)
      OP_AND:  y_o = &data_i;
      OP_NAND: y_o = ~&data_i;
      OP_OR:   y_o = |data_i;
      OP_NOR:  y_o = ~|data_i;
      OP_XOR:  y_o = ^data_i;
      OP_XNOR: y_o = ~^data_i;
      default: y_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/logic_gate_unit.sv
// Registered N_CH-channel gate array with valid/ready output stage and an
// exhaustive sweep self-test checked against a popcount-based golden model.
module logic_gate_unit
  import logic_gate_pkg::*;
#(
  parameter int N_IN = 2,
  parameter int N_CH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  logic_gate_unit_if.slave bus,
  input  logic [N_CH-1:0]  fault_inj,
  input  logic             bist_start,
  output logic             bist_busy,
  output logic             bist_done,
  output logic             bist_pass,
  output logic [ERR_W-1:0] bist_err_cnt
);

  localparam logic [2:0] LAST_OP = 3'(NUM_OPS - 1);

  bist_state_e      state_q, state_d;
  logic [2:0]       op_idx_q, op_idx_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic             pend_q, pend_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             pass_q, pass_d;
  logic             chk_q;
  logic [2:0]       chk_op_q;
  logic [N_IN-1:0]  chk_vec_q;
  logic             out_valid_q;
  logic [N_CH-1:0]  out_data_q;

  logic            sweep;
  logic            xfer;
  logic [2:0]      sel_op;
  logic [N_CH-1:0] gate_y;
  logic            mismatch;

  function automatic logic golden(input logic [2:0] op, input logic [N_IN-1:0] v);
    int ones;
    ones = $countones(v);
    case (op)
      OP_AND:  return ones == N_IN;
      OP_NAND: return ones != N_IN;
      OP_OR:   return ones != 0;
      OP_NOR:  return ones == 0;
      OP_XOR:  return ones[0];
      OP_XNOR: return !ones[0];
      default: return 1'b0;
    endcase
  endfunction

  assign sweep        = (state_q == SWEEP);
  assign bist_busy    = sweep || (state_q == DRAIN);
  assign bist_done    = (state_q == DONE);
  assign bist_pass    = pass_q;
  assign bist_err_cnt = err_q;

  assign bus.in_ready  = !bist_busy && (!out_valid_q || bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign xfer          = bus.in_valid && bus.in_ready;

  // During the sweep the counter replaces op and in_data on every channel.
  assign sel_op = sweep ? op_idx_q : bus.op;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [N_IN-1:0] sel_data;
      assign sel_data = sweep ? vec_q : bus.in_data[gi*N_IN +: N_IN];
      gate_channel #(.N_IN(N_IN)) u_gate (
        .op_i   (sel_op),
        .data_i (sel_data),
        .y_o    (gate_y[gi])
      );
    end
  endgenerate

  assign mismatch = chk_q && (out_data_q != {N_CH{golden(chk_op_q, chk_vec_q)}});

  always_comb begin
    state_d  = state_q;
    op_idx_d = op_idx_q;
    vec_d    = vec_q;
    pend_d   = pend_q;
    err_d    = err_q;
    pass_d   = pass_q;
    if (mismatch && (err_q != '1)) err_d = err_q + 1'b1;
    case (state_q)
      IDLE: begin
        // A start that collides with a live result or a new transfer waits.
        if ((bist_start || pend_q) && !out_valid_q && !xfer) begin
          state_d  = SWEEP;
          pend_d   = 1'b0;
          op_idx_d = '0;
          vec_d    = '0;
          err_d    = '0;
          pass_d   = 1'b0;
        end else if (bist_start) begin
          pend_d = 1'b1;
        end
      end
      SWEEP: begin
        vec_d = vec_q + 1'b1;
        if (vec_q == '1) begin
          op_idx_d = op_idx_q + 3'd1;
          if (op_idx_q == LAST_OP) state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = DONE;
        pass_d  = (err_d == '0);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_idx_q    <= '0;
      vec_q       <= '0;
      pend_q      <= 1'b0;
      err_q       <= '0;
      pass_q      <= 1'b0;
      chk_q       <= 1'b0;
      chk_op_q    <= '0;
      chk_vec_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_idx_q  <= op_idx_d;
      vec_q     <= vec_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
      pass_q    <= pass_d;
      chk_q     <= sweep;
      chk_op_q  <= op_idx_q;
      chk_vec_q <= vec_q;
      if (xfer || sweep) out_data_q <= gate_y ^ fault_inj;
      if (xfer) out_valid_q <= 1'b1;
      else if (bist_busy || bus.out_ready) out_valid_q <= 1'b0;
    end
  end

endmodule
